// File: rtl/audio_filter_sequencer.sv
// Clock-enable and coefficient sequencer for the audio IIR / DC-blocker chain:
// fractional-rate NCO, sample divider, warm-up gating and a mute/swap/re-warm coefficient update.
module audio_filter_sequencer #(
    parameter int CLK_RATE    = 22580650,
    parameter int FLT_CE_RATE = 12965400,
    parameter int SAMPLE_DIV  = 512,
    parameter int IIR_WARMUP  = 3,
    parameter int DC_WARMUP   = 8192,
    parameter int MUTE_HOLD   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [39:0] cfg_data,
    input  logic        cfg_rate,
    input  logic        cfg_commit,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2,
    output logic        iir_ce,
    output logic        iir_sample_ce,
    output logic        dc_ce,
    output logic        dc_sample_rate,
    output logic        dc_mute
);
    localparam int DW   = $clog2(SAMPLE_DIV);
    localparam int IW   = ($clog2(IIR_WARMUP + 1) < 1) ? 1 : $clog2(IIR_WARMUP + 1);
    localparam int SMAX = (DC_WARMUP > MUTE_HOLD) ? DC_WARMUP : MUTE_HOLD;
    localparam int SW   = ($clog2(SMAX + 1) < 1) ? 1 : $clog2(SMAX + 1);

    typedef enum logic [1:0] {ST_WARM, ST_RUN, ST_MUTE, ST_SWAP} state_t;

    typedef struct packed {
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } coef_t;

    localparam coef_t COEF_RST = '{
        cx:  40'd4258969,
        cx0: 8'd3,
        cx1: 8'd2,
        cx2: 8'd1,
        cy0: 24'(-6216759),
        cy1: 24'd6143386,
        cy2: 24'(-2023767)
    };

    coef_t          shadow;
    coef_t          active;
    state_t         state;
    logic [31:0]    acc;
    logic [32:0]    nco_sum;
    logic           flt_ce;
    logic           sample_ce;
    logic           rate;
    logic [DW-1:0]  div_cnt;
    logic [DW-1:0]  div_last;
    logic [IW-1:0]  iir_cnt;
    logic [SW-1:0]  sce_cnt;
    logic           iir_en;

    assign nco_sum  = {1'b0, acc} + 33'(FLT_CE_RATE);
    assign div_last = rate ? DW'(SAMPLE_DIV / 2 - 1) : DW'(SAMPLE_DIV - 1);
    // Warm-up counter saturates at IIR_WARMUP, so reaching it is the enable.
    assign iir_en   = (iir_cnt == IW'(IIR_WARMUP));

    assign cx             = active.cx;
    assign cx0            = active.cx0;
    assign cx1            = active.cx1;
    assign cx2            = active.cx2;
    assign cy0            = active.cy0;
    assign cy1            = active.cy1;
    assign cy2            = active.cy2;
    assign iir_ce         = flt_ce & iir_en;
    assign iir_sample_ce  = sample_ce;
    assign dc_ce          = sample_ce;
    assign dc_sample_rate = rate;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= COEF_RST;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    shadow.cx  <= cfg_data;
                3'd1:    shadow.cx0 <= cfg_data[7:0];
                3'd2:    shadow.cx1 <= cfg_data[7:0];
                3'd3:    shadow.cx2 <= cfg_data[7:0];
                3'd4:    shadow.cy0 <= cfg_data[23:0];
                3'd5:    shadow.cy1 <= cfg_data[23:0];
                3'd6:    shadow.cy2 <= cfg_data[23:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active    <= COEF_RST;
            state     <= ST_WARM;
            rate      <= 1'b0;
            acc       <= '0;
            flt_ce    <= 1'b0;
            div_cnt   <= '0;
            sample_ce <= 1'b0;
            iir_cnt   <= '0;
            sce_cnt   <= '0;
            dc_mute   <= 1'b1;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (state == ST_SWAP) begin
                // Restart both enable generators and warm-ups; enables landing here are dropped.
                active    <= shadow;
                rate      <= cfg_rate;
                acc       <= '0;
                flt_ce    <= 1'b0;
                div_cnt   <= '0;
                sample_ce <= 1'b0;
                iir_cnt   <= '0;
                sce_cnt   <= '0;
                dc_mute   <= 1'b1;
                cfg_busy  <= 1'b1;
                state     <= ST_WARM;
            end else begin
                if (nco_sum >= 33'(CLK_RATE)) begin
                    acc    <= 32'(nco_sum - 33'(CLK_RATE));
                    flt_ce <= 1'b1;
                end else begin
                    acc    <= nco_sum[31:0];
                    flt_ce <= 1'b0;
                end

                sample_ce <= (div_cnt == div_last);
                div_cnt   <= (div_cnt == div_last) ? '0 : div_cnt + DW'(1);

                if (flt_ce && !iir_en)
                    iir_cnt <= iir_cnt + IW'(1);

                case (state)
                    ST_WARM: begin
                        if (sample_ce && sce_cnt != SW'(DC_WARMUP)) begin
                            sce_cnt <= sce_cnt + SW'(1);
                            if (sce_cnt == SW'(DC_WARMUP - 1))
                                dc_mute <= 1'b0;
                        end
                        if (iir_en && !dc_mute) begin
                            state    <= ST_RUN;
                            cfg_done <= 1'b1;
                            cfg_busy <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (cfg_commit) begin
                            state    <= ST_MUTE;
                            cfg_busy <= 1'b1;
                            dc_mute  <= 1'b1;
                            sce_cnt  <= '0;
                        end
                    end
                    ST_MUTE: begin
                        // Same counter now measures the mute hold before the swap.
                        if (sample_ce) begin
                            if (sce_cnt == SW'(MUTE_HOLD - 1))
                                state <= ST_SWAP;
                            else
                                sce_cnt <= sce_cnt + SW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_audio_filter_sequencer.sv
// Bench for audio_filter_sequencer: expected output values are queued per cycle when stimulus
// is driven and compared by a negedge monitor when that cycle arrives.
module tb_audio_filter_sequencer;
    localparam int CLKR = 10;
    localparam int FLT  = 3;
    localparam int SDIV = 8;
    localparam int IIRW = 2;
    localparam int DCW  = 4;
    localparam int MH   = 2;

    localparam logic [39:0] CX_DEF  = 40'd4258969;
    localparam logic [7:0]  CX0_DEF = 8'd3;
    localparam logic [7:0]  CX1_DEF = 8'd2;
    localparam logic [7:0]  CX2_DEF = 8'd1;
    localparam logic [23:0] CY0_DEF = 24'hA123C9;
    localparam logic [23:0] CY1_DEF = 24'd6143386;
    localparam logic [23:0] CY2_DEF = 24'hE11EA9;

    localparam int S_IIR = 0, S_SMP = 1, S_DCE = 2, S_MUTE = 3, S_BUSY = 4, S_DONE = 5, S_RATE = 6;
    localparam int S_CX = 7, S_CX0 = 8, S_CX1 = 9, S_CX2 = 10, S_CY0 = 11, S_CY1 = 12, S_CY2 = 13;
    localparam int NSIG = 14;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we, cfg_rate, cfg_commit;
    logic [2:0]  cfg_addr;
    logic [39:0] cfg_data;
    logic        cfg_busy, cfg_done, iir_ce, iir_sample_ce, dc_ce, dc_sample_rate, dc_mute;
    logic [39:0] cx;
    logic [7:0]  cx0, cx1, cx2;
    logic [23:0] cy0, cy1, cy2;

    audio_filter_sequencer #(
        .CLK_RATE(CLKR), .FLT_CE_RATE(FLT), .SAMPLE_DIV(SDIV),
        .IIR_WARMUP(IIRW), .DC_WARMUP(DCW), .MUTE_HOLD(MH)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_rate(cfg_rate), .cfg_commit(cfg_commit),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cx(cx), .cx0(cx0), .cx1(cx1), .cx2(cx2), .cy0(cy0), .cy1(cy1), .cy2(cy2),
        .iir_ce(iir_ce), .iir_sample_ce(iir_sample_ce), .dc_ce(dc_ce),
        .dc_sample_rate(dc_sample_rate), .dc_mute(dc_mute)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // Filter pulse m edges after an NCO restart: floor(FLT*m/CLKR) steps up.
    function automatic bit flt_at(int m);
        return (m >= 1) && ((FLT * m) / CLKR != (FLT * (m - 1)) / CLKR);
    endfunction

    function automatic bit iir_exp(int m);
        return flt_at(m) && ((FLT * (m - 1)) / CLKR >= IIRW);
    endfunction

    function automatic string sig_name(int id);
        case (id)
            S_IIR:  return "iir_ce";
            S_SMP:  return "iir_sample_ce";
            S_DCE:  return "dc_ce";
            S_MUTE: return "dc_mute";
            S_BUSY: return "cfg_busy";
            S_DONE: return "cfg_done";
            S_RATE: return "dc_sample_rate";
            S_CX:   return "cx";
            S_CX0:  return "cx0";
            S_CX1:  return "cx1";
            S_CX2:  return "cx2";
            S_CY0:  return "cy0";
            S_CY1:  return "cy1";
            default: return "cy2";
        endcase
    endfunction

    function automatic logic [63:0] sig_val(int id);
        case (id)
            S_IIR:  return 64'(iir_ce);
            S_SMP:  return 64'(iir_sample_ce);
            S_DCE:  return 64'(dc_ce);
            S_MUTE: return 64'(dc_mute);
            S_BUSY: return 64'(cfg_busy);
            S_DONE: return 64'(cfg_done);
            S_RATE: return 64'(dc_sample_rate);
            S_CX:   return 64'(cx);
            S_CX0:  return 64'(cx0);
            S_CX1:  return 64'(cx1);
            S_CX2:  return 64'(cx2);
            S_CY0:  return 64'(cy0);
            S_CY1:  return 64'(cy1);
            default: return 64'(cy2);
        endcase
    endfunction

    function automatic logic [63:0] def_val(int id);
        case (id)
            S_MUTE, S_BUSY: return 64'd1;
            S_CX:   return 64'(CX_DEF);
            S_CX0:  return 64'(CX0_DEF);
            S_CX1:  return 64'(CX1_DEF);
            S_CX2:  return 64'(CX2_DEF);
            S_CY0:  return 64'(CY0_DEF);
            S_CY1:  return 64'(CY1_DEF);
            S_CY2:  return 64'(CY2_DEF);
            default: return 64'd0;
        endcase
    endfunction

    task automatic push(input int c, input int id, input logic [63:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = id;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic push_bank(input int c, input logic [23:0] cy0v);
        for (int id = S_CX; id <= S_CY2; id++)
            push(c, id, (id == S_CY0) ? 64'(cy0v) : def_val(id));
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        exp_t keep[$];
        if (!reset) begin
            keep = {};
            foreach (sb[i]) begin
                if (sb[i].cyc == cyc)
                    chk($sformatf("%s@%0d", sig_name(sb[i].sig), cyc), sig_val(sb[i].sig), sb[i].val);
                else
                    keep.push_back(sb[i]);
            end
            sb = keep;
        end
    end

    initial begin
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 40'd0; cfg_rate = 1'b0; cfg_commit = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NSIG; i++)
            chk($sformatf("rst_%s", sig_name(i)), sig_val(i), def_val(i));

        // Power-up: NCO cadence, divider, iir mask, dc warm-up, first cfg_done.
        for (int n = 1; n <= 100; n++) begin
            push(n, S_IIR,  64'(iir_exp(n)));
            push(n, S_SMP,  64'(n % SDIV == 0));
            push(n, S_DCE,  64'(n % SDIV == 0));
            push(n, S_MUTE, 64'(n <= DCW * SDIV));
            push(n, S_BUSY, 64'(n <= DCW * SDIV + 1));
            push(n, S_DONE, 64'(n == DCW * SDIV + 2));
        end
        push_bank(50, CY0_DEF);
        push(50, S_RATE, 64'd0);
        reset = 1'b0;

        // cy0 update: MUTE 102..112, SWAP at 113, new bank from 114, RUN again at 148.
        wait_cyc(100);
        for (int n = 102; n <= 160; n++) begin
            push(n, S_IIR,  64'((n <= 113) ? flt_at(n) : iir_exp(n - 114)));
            push(n, S_SMP,  64'((n <= 113) ? (n % 8 == 0) : (n > 114 && (n - 114) % 8 == 0)));
            push(n, S_MUTE, 64'(n <= 146));
            push(n, S_BUSY, 64'(n <= 147));
            push(n, S_DONE, 64'(n == 148));
            push(n, S_CY0,  (n <= 113) ? 64'(CY0_DEF) : 64'h123456);
        end
        push_bank(115, 24'h123456);
        push_bank(155, 24'h123456);
        push(150, S_RATE, 64'd0);
        cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 40'h123456;
        wait_cyc(101);
        cfg_we = 1'b0; cfg_commit = 1'b1;
        wait_cyc(102);
        cfg_commit = 1'b0;

        // Half-rate commit; stray commits in MUTE (165) and WARM (180) must be dropped.
        wait_cyc(160);
        for (int n = 161; n <= 201; n++) begin
            push(n, S_IIR,  64'((n <= 171) ? flt_at(n - 114) : iir_exp(n - 172)));
            push(n, S_SMP,  64'((n <= 171) ? ((n - 114) % 8 == 0) : (n > 172 && (n - 172) % 4 == 0)));
            push(n, S_DCE,  64'((n <= 171) ? ((n - 114) % 8 == 0) : (n > 172 && (n - 172) % 4 == 0)));
            push(n, S_RATE, 64'(n >= 172));
            push(n, S_MUTE, 64'(n <= 188));
            push(n, S_BUSY, 64'(n <= 189));
            push(n, S_DONE, 64'(n == 190));
        end
        push_bank(185, 24'h123456);
        cfg_commit = 1'b1; cfg_rate = 1'b1;
        wait_cyc(161);
        cfg_commit = 1'b0;
        wait_cyc(164);
        cfg_commit = 1'b1;
        wait_cyc(165);
        cfg_commit = 1'b0;
        wait_cyc(180);
        cfg_commit = 1'b1;
        wait_cyc(181);
        cfg_commit = 1'b0;

        // Address-7 write then commit: bank after SWAP (at 210) must be unchanged.
        wait_cyc(200);
        for (int n = 202; n <= 240; n++) begin
            push(n, S_IIR,  64'((n <= 209) ? flt_at(n - 172) : iir_exp(n - 210)));
            push(n, S_SMP,  64'((n <= 209) ? ((n - 172) % 4 == 0) : (n > 210 && (n - 210) % 4 == 0)));
            push(n, S_RATE, 64'd1);
            push(n, S_MUTE, 64'(n <= 226));
            push(n, S_BUSY, 64'(n <= 227));
            push(n, S_DONE, 64'(n == 228));
        end
        push_bank(215, 24'h123456);
        push_bank(235, 24'h123456);
        cfg_we = 1'b1; cfg_addr = 3'd7; cfg_data = 40'hFF_FFFF_FFFF;
        wait_cyc(201);
        cfg_we = 1'b0; cfg_commit = 1'b1;
        wait_cyc(202);
        cfg_commit = 1'b0;

        // Shadow write + commit, then reset in MUTE: everything, shadow included, returns to defaults.
        wait_cyc(240);
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 40'hAA;
        wait_cyc(241);
        cfg_we = 1'b0; cfg_commit = 1'b1;
        wait_cyc(242);
        cfg_commit = 1'b0;
        wait_cyc(244);
        chk("mute_before_reset", 64'(dc_mute), 64'd1);
        chk("busy_before_reset", 64'(cfg_busy), 64'd1);
        chk("sb_drain_pre_reset", 64'(sb.size()), 64'd0);
        reset = 1'b1; cfg_rate = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NSIG; i++)
            chk($sformatf("rst2_%s", sig_name(i)), sig_val(i), def_val(i));

        for (int n = 1; n <= 40; n++) begin
            push(n, S_MUTE, 64'(n <= 32));
            push(n, S_BUSY, 64'(n <= 33));
            push(n, S_DONE, 64'(n == 34));
        end
        for (int n = 58; n <= 60; n++) begin
            push_bank(n, CY0_DEF);
            push(n, S_MUTE, 64'd1);
            push(n, S_RATE, 64'd0);
        end
        reset = 1'b0;
        wait_cyc(40);
        cfg_commit = 1'b1;
        wait_cyc(41);
        cfg_commit = 1'b0;
        wait_cyc(65);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_filter_sequencer.md
# audio_filter_sequencer

Parametrised clock-enable and coefficient sequencer for the audio IIR/DC-blocker chain. It sits between the system clock domain and the `audio_iir`/`audio_dc_blocker` datapaths. It generates a fractional-rate filter enable and an integer-divided sample enable, and gates both through power-up warm-up delays. Unlike the fixed-coefficient controller it replaces, it holds a runtime-writable, double-buffered coefficient bank and a selectable sample rate, and applies a committed change through a glitch-free mute → swap → re-warm sequence.

## Interface
Parameters:
- CLK_RATE, 22580650 — clk frequency in Hz; NCO modulus.
- FLT_CE_RATE, 12965400 — filter enable rate in Hz; must satisfy 0 < FLT_CE_RATE < CLK_RATE.
- SAMPLE_DIV, 512 — clk cycles per sample_ce when rate is 0; even, ≥ 4.
- IIR_WARMUP, 3 — number of flt_ce pulses suppressed before iir_ce passes.
- DC_WARMUP, 8192 — number of sample_ce pulses before dc_mute releases.
- MUTE_HOLD, 64 — number of sample_ce pulses dc_mute is held before a coefficient swap.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- cfg_we  in  1  shadow-bank write strobe.
- cfg_addr  in  3  0=cx, 1=cx0, 2=cx1, 3=cx2, 4=cy0, 5=cy1, 6=cy2, 7=no effect.
- cfg_data  in  40  write data, LSB-aligned to the target width (cx 40, cx* 8, cy* 24).
- cfg_rate  in  1  sample-rate select applied at the next commit: 0=SAMPLE_DIV, 1=SAMPLE_DIV/2.
- cfg_commit  in  1  single-cycle request to apply the shadow bank.
- cfg_busy  out  1  high whenever the state is not RUN.
- cfg_done  out  1  one-cycle pulse on every WARM→RUN transition.
- cx  out  40; cx0, cx1, cx2  out  8; cy0, cy1, cy2  out  24 — active coefficient bank, registered.
- iir_ce  out  1  flt_ce AND iir_en.
- iir_sample_ce, dc_ce  out  1  both equal sample_ce.
- dc_sample_rate  out  1  active rate select.
- dc_mute  out  1  mute request to the DC stage.

## Operation
- Reset values: active and shadow banks = {cx 4258969, cx0 3, cx1 2, cx2 1, cy0 −6216759, cy1 6143386, cy2 −2023767} (cy in 24-bit two's complement). Rate = 0. NCO accumulator = 0. Divider = 0. All enables = 0. dc_mute = 1. State = WARM. cfg_busy = 1. cfg_done = 0.
- NCO: 32-bit accumulator. Each cycle, compute s = acc + FLT_CE_RATE. If s ≥ CLK_RATE, then acc ← s − CLK_RATE and flt_ce ← 1; otherwise acc ← s and flt_ce ← 0. Over CLK_RATE cycles this yields exactly FLT_CE_RATE pulses.
- Sample divider: counts 0..D−1, where D = SAMPLE_DIV >> rate. sample_ce is registered high for one cycle when count = D−1, after which the count wraps to 0.
- Shadow writes: accepted in every state. Writes to address 7 have no effect. The active bank changes only in SWAP.
- States:
  - WARM: dc_mute = 1. iir_en rises after IIR_WARMUP flt_ce pulses have been counted. dc_mute falls after DC_WARMUP sample_ce pulses have been counted. When iir_en = 1 and dc_mute = 0, go to RUN and pulse cfg_done.
  - RUN: a cfg_commit moves to MUTE. A cfg_commit in any other state is ignored and not queued.
  - MUTE: dc_mute = 1 from the first MUTE cycle. iir_ce continues. After MUTE_HOLD sample_ce pulses, go to SWAP.
  - SWAP (exactly one cycle): active bank ← shadow; rate ← cfg_rate as sampled in this cycle; accumulator, divider, and both warm-up counters ← 0; iir_en ← 0. Next state is WARM.
- Warm-up counters saturate and do not wrap. A flt_ce or sample_ce coinciding with SWAP is discarded.
- A reset asserted mid-sequence returns every register to its reset value, including the shadow bank. Any pending commit is lost.

## Timing
- flt_ce and sample_ce are registered: one cycle after the counter condition is met.
- First sample_ce after reset release occurs on clk edge D (count 0..D−1 plus the output register).
- iir_ce: the first IIR_WARMUP flt_ce pulses in WARM are masked. Pulse IIR_WARMUP+1 passes, in the same cycle as flt_ce.
- dc_mute deasserts in the cycle after the DC_WARMUP-th sample_ce.
- Commit latency: RUN→MUTE on the edge after cfg_commit. cfg_busy rises at that same edge.
- New coefficients are visible on the edge after the SWAP cycle.
- cfg_done and the RUN state are both visible in the cycle after the warm-up conditions are met. cfg_busy falls in that same cycle.

## Test plan
Bench parameters: CLK_RATE=10, FLT_CE_RATE=3, SAMPLE_DIV=8, IIR_WARMUP=2, DC_WARMUP=4, MUTE_HOLD=2.

1. Release reset, run 100 cycles → exactly 30 flt_ce pulses with gaps of 3/3/4 cycles; sample_ce every 8 cycles, first at edge 8.
2. Power-up → iir_ce masked for the first 2 flt_ce pulses and passes from the 3rd; dc_mute falls the cycle after the 4th sample_ce; cfg_done pulses once; cfg_busy falls in the same cycle.
3. In RUN, write addr 4 = 0x123456, then commit → dc_mute = 1 for 2 sample_ce pulses; cy0 = 0x123456 after SWAP; cx and the other coefficients are unchanged; iir_ce masked for 2 further flt_ce pulses; cfg_done pulses again.
4. Commit with cfg_rate = 1 → after SWAP, sample_ce period = 4 cycles and dc_sample_rate = 1.
5. Commit asserted during MUTE and during WARM → ignored; exactly one swap occurs. A write to address 7 leaves all outputs unchanged.
6. Assert reset during MUTE after a shadow write → all coefficient outputs return to the defaults, dc_mute = 1, and the state is WARM.
